// File: rtl/register_bank_pkg.sv
// Shared definitions for the register bank: reset value default and clear-sweep FSM encoding.
package register_bank_pkg;

    localparam int unsigned RESET_VAL_DEFAULT = 0;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

endpackage

// File: rtl/register_bank_if.sv
// Register bank bus: one write port, two read ports, clear request and busy status.
interface register_bank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
);
    localparam int AW = $clog2(DEPTH);

    // No backpressure: a write is taken when load=1 and busy=0 at the edge, otherwise dropped;
    // rd_en_x qualifies a read whose data/valid appear registered one edge later and then hold.
    logic             load;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] data_in;
    logic             rd_en_a;
    logic [AW-1:0]    rd_addr_a;
    logic [WIDTH-1:0] data_out_a;
    logic             valid_a;
    logic             rd_en_b;
    logic [AW-1:0]    rd_addr_b;
    logic [WIDTH-1:0] data_out_b;
    logic             valid_b;
    logic             clear;
    logic             busy;

    modport master (
        output load, wr_addr, data_in, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clear,
        input  data_out_a, valid_a, data_out_b, valid_b, busy
    );

    modport slave (
        input  load, wr_addr, data_in, rd_en_a, rd_addr_a, rd_en_b, rd_addr_b, clear,
        output data_out_a, valid_a, data_out_b, valid_b, busy
    );

endinterface

// File: rtl/register_bank_rdport.sv
// One registered read port: address range check, optional write-through mux, output registers.
module register_bank_rdport #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = $clog2(DEPTH),
    parameter bit BYPASS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] mem [DEPTH],
    input  logic [DEPTH-1:0] written,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] data_out,
    output logic             valid
);

    logic             in_range;
    logic             hit;
    logic [WIDTH-1:0] next_data;
    logic             next_valid;

    // Extra bit so a power-of-two DEPTH does not wrap to zero in the compare.
    assign in_range = ({1'b0, rd_addr} < (AW + 1)'(DEPTH));
    assign hit      = wr_en && (wr_addr == rd_addr);

    always_comb begin
        next_data  = '0;
        next_valid = 1'b0;
        if (in_range) begin
            next_data  = mem[rd_addr];
            next_valid = written[rd_addr];
            if (BYPASS && hit) begin
                next_data  = wr_data;
                next_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            valid    <= 1'b0;
        end else if (rd_en) begin
            data_out <= next_data;
            valid    <= next_valid;
        end
    end

endmodule

// File: rtl/register_bank.sv
// DEPTH x WIDTH register bank with written flags, two registered read ports and a clear sweep.
// Build option: define REGISTER_BANK_BYPASS_EN for write-through reads (default read-before-write).
module register_bank
    import register_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_VAL_DEFAULT)
) (
    input  logic                   clk,
    input  logic                   rst,
    register_bank_if.slave         bus,
    output state_t                 state
);

    localparam int          AW   = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

`ifdef REGISTER_BANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] written;
    logic [AW-1:0]    ptr;
    logic             busy;
    logic             wr_en;

    assign wr_en    = bus.load && !busy && ({1'b0, bus.wr_addr} < (AW + 1)'(DEPTH));
    assign bus.busy = busy;

    // A write and the sweep never collide: writes are blocked for the whole sweep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
            written <= '0;
            ptr     <= '0;
            busy    <= 1'b0;
            state   <= ST_IDLE;
        end else begin
            if (wr_en) begin
                mem[bus.wr_addr]     <= bus.data_in;
                written[bus.wr_addr] <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        state <= ST_SWEEP;
                        busy  <= 1'b1;
                        ptr   <= '0;
                    end
                end
                ST_SWEEP: begin
                    mem[ptr]     <= RESET_VAL;
                    written[ptr] <= 1'b0;
                    if (ptr == LAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    ptr   <= '0;
                end
            endcase
        end
    end

    register_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_rd_a (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (bus.rd_en_a),
        .rd_addr  (bus.rd_addr_a),
        .mem      (mem),
        .written  (written),
        .wr_en    (wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.data_in),
        .data_out (bus.data_out_a),
        .valid    (bus.valid_a)
    );

    register_bank_rdport #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS)) u_rd_b (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (bus.rd_en_b),
        .rd_addr  (bus.rd_addr_b),
        .mem      (mem),
        .written  (written),
        .wr_en    (wr_en),
        .wr_addr  (bus.wr_addr),
        .wr_data  (bus.data_in),
        .data_out (bus.data_out_b),
        .valid    (bus.valid_b)
    );

endmodule
